// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive path.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int CNT_W      = $clog2(OVERSAMPLE);
    localparam int IDX_W      = $clog2(DATA_BITS) + 1;

    // Half-period count for the 16x baud tick from a 100 MHz system clock.
    localparam int BAUD_DIV   = 326;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs that idle high.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b1;
            q  <= 1'b1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver running on the 16x oversampled baud clock.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
    input  logic                 clk_baud,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS) + 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST    = IW'(DATA_BITS - 1);

    logic                 rxs;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    sync_2ff u_sync (
        .clk   (clk_baud),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

    always_ff @(posedge clk_baud) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rxs) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Hold here while the line stays low so a break reports once.
                    cnt <= '0;
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
